// File: rtl/xilinx_distram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// xilinx_distram_pkg
// Shared types and helpers for the distributed-RAM arbiter slice.
//   state_e  : controller state (INIT = zero-fill sweep, RUN = serving requests)
//   pick_t   : result of a round-robin search (found flag + index)
//   rr_pick  : round-robin search over up to MAX_REQ request bits
// ---------------------------------------------------------------------------
package xilinx_distram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Largest requester count the search helper handles; callers zero-extend.
  localparam int unsigned MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of valid at or above ptr, wrapping modulo num_req.
  // Only the lowest num_req bits of valid take part in the search.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [2:0]         ptr,
                                    input int unsigned        num_req);
    pick_t       res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = (32'(ptr) + k) % num_req;
      if ((k < num_req) && !res.found && valid[cand[2:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/xilinx_distram_arbiter_if.sv
// ---------------------------------------------------------------------------
// xilinx_distram_arbiter_if
// Request/response bundle between client logic and the RAM arbiter.
//   REQ_VALID/REQ_READY : per-requester handshake (READY is a one-hot grant)
//   REQ_WE/ADDR/WDATA   : packed per-requester access fields
//   RSP_VALID/RSP_RDATA : one-cycle read response strobe + shared data
//   INIT_DONE           : zero-fill sweep has completed
// Modports: master = client side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface xilinx_distram_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            REQ_VALID;
  logic [NUM_REQ-1:0]            REQ_READY;
  logic [NUM_REQ-1:0]            REQ_WE;
  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA;
  logic [NUM_REQ-1:0]            RSP_VALID;
  logic [DATA_WIDTH-1:0]         RSP_RDATA;
  logic                          INIT_DONE;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA, INIT_DONE
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA, INIT_DONE
  );

endinterface

// File: rtl/xilinx_rr_arbiter.sv
// ---------------------------------------------------------------------------
// xilinx_rr_arbiter
// Combinational round-robin pick with a registered priority pointer.
//   clk_i/rst_i   : clock, asynchronous active-high reset (pointer -> 0)
//   en_i          : arbitration enabled; no grant while low
//   valid_i       : per-requester request bits
//   grant_o       : one-hot grant
//   grant_idx_o   : index of the granted requester
//   found_o       : a grant is issued this cycle
// After a grant to g the pointer moves to (g+1) mod NUM_REQ; otherwise holds.
// ---------------------------------------------------------------------------
module xilinx_rr_arbiter
  import xilinx_distram_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               found_o
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pick;

  assign valid_ext   = MAX_REQ'(valid_i);
  assign pick        = rr_pick(valid_ext, 3'(ptr_q), NUM_REQ);
  assign found_o     = en_i & pick.found;
  assign grant_idx_o = IDX_W'(pick.idx);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant_o[gi] = found_o && (pick.idx == 3'(gi));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found_o) begin
      ptr_d = (grant_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/xilinx_sp_distram.sv
// ---------------------------------------------------------------------------
// xilinx_sp_distram
// Single-port distributed (LUT) RAM: synchronous write, asynchronous read.
//   clk_i   : write clock
//   we_i    : write enable
//   addr_i  : shared read/write address
//   wdata_i : write data
//   rdata_o : combinational read data at addr_i
// Contents are not reset.
// ---------------------------------------------------------------------------
module xilinx_sp_distram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/xilinx_distram_arbiter.sv
// ---------------------------------------------------------------------------
// xilinx_distram_arbiter
// Shares one single-port LUT RAM between NUM_REQ requesters, one access per
// clock, round-robin. After reset the RAM is zero-filled (DEPTH cycles)
// before any request is granted. Reads return one cycle after grant.
//   CLK : clock (also the RAM write clock)
//   RST : asynchronous active-high reset
//   bus : slave side of xilinx_distram_arbiter_if (handshake, response,
//         INIT_DONE)
// ---------------------------------------------------------------------------
module xilinx_distram_arbiter
  import xilinx_distram_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  xilinx_distram_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_found;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Unpacked views of the packed per-requester fields.
  logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_wdata [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_addr[gi]  = bus.REQ_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_wdata[gi] = bus.REQ_WDATA[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  xilinx_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk_i       (CLK),
    .rst_i       (RST),
    .en_i        (state_q == RUN),
    .valid_i     (bus.REQ_VALID),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .found_o     (grant_found)
  );

  xilinx_sp_distram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_we      = 1'b0;
    ram_addr    = cnt_q;
    ram_wdata   = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      INIT: begin
        ram_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        // The counter wraps to 0 on the same edge that leaves INIT.
        if (cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (grant_found) begin
          ram_addr  = req_addr[grant_idx];
          ram_wdata = req_wdata[grant_idx];
          ram_we    = bus.REQ_WE[grant_idx];
          if (!bus.REQ_WE[grant_idx]) begin
            rsp_valid_d = grant;
            rsp_rdata_d = ram_rdata;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.REQ_READY = grant;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.INIT_DONE = (state_q == RUN);

endmodule
